imul_seq: RTL

IMUL_SEQ -- requirements
Module: imul_seq

---
 rtl/imul_seq.sv | 96 +++++++++
 1 files changed

// File: rtl/imul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per clock, LSB first.
// Signed mode multiplies magnitudes and negates the full-width product at the end.
module imul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  input  logic                 iSigned,
  input  logic                 iValid,
  output logic                 oReady,
  output logic [2*WIDTH-1:0]   oResult,
  output logic                 oValid,
  input  logic                 iReady
);

  // IDLE: accept operands | BUSY: one multiplier bit per edge | DONE: hold result until iReady
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_product;

  // Magnitudes stay WIDTH bits wide: -(2^(WIDTH-1)) maps to 2^(WIDTH-1) unsigned.
  assign w_mag_a    = (iSigned && iA[WIDTH-1]) ? -iA : iA;
  assign w_mag_b    = (iSigned && iB[WIDTH-1]) ? -iB : iB;
  assign w_accept   = (r_state == IDLE) && iValid;
  assign w_last     = (r_state == BUSY) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_addend   = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
  assign w_acc_next = r_acc + w_addend;
  assign w_product  = r_neg ? -w_acc_next : w_acc_next;
  assign oResult    = r_result;

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    oReady       = 1'b0;
    oValid       = 1'b0;
    case (r_state)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        oValid = 1'b1;
        if (iReady) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_mag_a;
      r_mplier <= w_mag_b;
      r_neg    <= iSigned && (iA[WIDTH-1] ^ iB[WIDTH-1]);
      r_cnt    <= '0;
      r_acc    <= '0;
    end else if (r_state == BUSY) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) r_result <= w_product;
    end
  end

endmodule
